// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//  Shared definitions for the registered ALU (alu_pipe) and its sequential
//  multiplier (alu_mul_seq).
//  Contents:
//   - 4-bit opcode encodings ALU_AND .. ALU_EQ and ALU_MUL
//   - FSM state encoding (ST_IDLE, ST_MUL)
//   - signed-overflow helper functions for ADD and SUB, driven by sign bits
//  Optional feature macro: ALU_PIPE_MUL_EN (used by alu_pipe; ST_MUL and
//  ALU_MUL are only meaningful when it is defined).
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_SLL  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SRA  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;
   localparam logic [3:0] ALU_MUL  = 4'b1010;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
   localparam logic [3:0] ALU_EQ   = 4'b1111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   // Two's-complement add overflows when both operands share a sign and the
   // result sign differs from it.
   function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
      return (a_msb == b_msb) && (r_msb != a_msb);
   endfunction

   // a-b overflows when the operand signs differ and the result sign is not a's.
   function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
      return (a_msb != b_msb) && (r_msb != a_msb);
   endfunction

endpackage

// File: rtl/alu_pipe_mul.sv
// ---------------------------------------------------------------------------
// alu_mul_seq
//  Unsigned shift-add multiplier, one multiplier bit per cycle.
//  The first partial product is folded into the start cycle, so the final
//  product is in place and done pulses WIDTH-1 cycles after start; the parent
//  registers it on the following edge, i.e. WIDTH cycles after acceptance.
//  Only instantiated when ALU_PIPE_MUL_EN is defined.
//  Ports:
//   clk      in   1         rising-edge clock
//   rst      in   1         asynchronous active-high reset (abandons the op)
//   start    in   1         load operands and begin
//   a        in   WIDTH     multiplicand
//   b        in   WIDTH     multiplier
//   done     out  1         one-cycle pulse, product valid
//   product  out  2*WIDTH   full unsigned product
// ---------------------------------------------------------------------------
module alu_mul_seq #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic [2*WIDTH-1:0] acc_r;
   logic [2*WIDTH-1:0] mcand_r;
   logic [WIDTH-1:0]   mplier_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               busy_r;
   logic               done_r;

   // Shift-add iteration: consume one multiplier bit per cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r    <= '0;
         mcand_r  <= '0;
         mplier_r <= '0;
         cnt_r    <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (start) begin
            // bit 0 handled here so the op completes in WIDTH cycles overall
            acc_r    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand_r  <= {{WIDTH{1'b0}}, a} << 1;
            mplier_r <= b >> 1;
            cnt_r    <= CNT_W'(1);
            busy_r   <= 1'b1;
         end else if (busy_r) begin
            if (mplier_r[0]) begin
               acc_r <= acc_r + mcand_r;
            end
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CNT_W'(1);
            if (cnt_r == CNT_W'(WIDTH - 1)) begin
               busy_r <= 1'b0;
               done_r <= 1'b1;
            end
         end
      end
   end

   assign done    = done_r;
   assign product = acc_r;

endmodule

// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe
//  Registered ALU with valid/ready on both sides. Single-cycle ops are
//  computed combinationally and captured in the output register; at most one
//  result is in flight. A tag travels with each operation.
//  Optional feature macro: ALU_PIPE_MUL_EN -- builds the WIDTH-cycle
//  sequential unsigned multiplier for opcode 1010. Without it, 1010 is ADD
//  and no FSM or multiplier logic exists.
//  Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        operand handshake
//   a_in, b_in, alu_ctrl     operands and opcode (shifts use low log2(WIDTH) bits of b_in)
//   tag_in / tag_out         issue tag, passed through unchanged
//   out_valid/out_ready      result handshake
//   alu_out                  registered result
//   zero, overflow, carry_out registered flags
// ---------------------------------------------------------------------------
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [3:0]       alu_ctrl,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_out,
   output logic [TAG_W-1:0] tag_out,
   output logic             zero,
   output logic             overflow,
   output logic             carry_out
);

   localparam int SH_W = $clog2(WIDTH);

   logic [WIDTH:0]     add_s;
   logic [WIDTH:0]     sub_s;
   logic [SH_W-1:0]    sh_s;
   logic [WIDTH-1:0]   res_s;
   logic               cout_s;
   logic               ovf_s;
   logic               push_s;
   logic               pop_s;
   logic               is_mul_s;
   logic               idle_s;

   logic               out_valid_r;
   logic [WIDTH-1:0]   alu_out_r;
   logic [TAG_W-1:0]   tag_out_r;
   logic               zero_r;
   logic               overflow_r;
   logic               carry_r;

`ifdef ALU_PIPE_MUL_EN
   state_t             state_r;
   logic [TAG_W-1:0]   mul_tag_r;
   logic               mul_done_s;
   logic [2*WIDTH-1:0] mul_prod_s;

   assign is_mul_s = (alu_ctrl == ALU_MUL);
   assign idle_s   = (state_r == ST_IDLE);
`else
   assign is_mul_s = 1'b0;
   assign idle_s   = 1'b1;
`endif

   // rst is folded in so nothing is accepted while reset is held
   assign in_ready = ~rst & idle_s & (~out_valid_r | out_ready);
   assign push_s   = in_valid & in_ready;
   assign pop_s    = out_valid_r & out_ready;
   assign sh_s     = b_in[SH_W-1:0];

   // Single-cycle datapath; unlisted opcodes fall through to ADD.
   always_comb begin
      add_s  = {1'b0, a_in} + {1'b0, b_in};
      sub_s  = {1'b0, a_in} + {1'b0, ~b_in} + {{WIDTH{1'b0}}, 1'b1};
      res_s  = '0;
      cout_s = 1'b0;
      ovf_s  = 1'b0;
      case (alu_ctrl)
         ALU_AND:  res_s = a_in & b_in;
         ALU_OR:   res_s = a_in | b_in;
         ALU_XOR:  res_s = a_in ^ b_in;
         ALU_NOR:  res_s = ~(a_in | b_in);
         ALU_SLL:  res_s = a_in << sh_s;
         ALU_SRL:  res_s = a_in >> sh_s;
         ALU_SRA:  res_s = $unsigned($signed(a_in) >>> sh_s);
         ALU_SLT:  res_s = {{(WIDTH-1){1'b0}}, ($signed(a_in) < $signed(b_in))};
         ALU_SLTU: res_s = {{(WIDTH-1){1'b0}}, (a_in < b_in)};
         ALU_EQ:   res_s = {{(WIDTH-1){1'b0}}, (a_in == b_in)};
         ALU_SUB: begin
            res_s  = sub_s[WIDTH-1:0];
            cout_s = sub_s[WIDTH];
            ovf_s  = sub_ovf(a_in[WIDTH-1], b_in[WIDTH-1], sub_s[WIDTH-1]);
         end
`ifdef ALU_PIPE_MUL_EN
         ALU_MUL: begin
            // result comes from the multiplier, not from this path
            res_s = '0;
         end
`endif
         default: begin
            res_s  = add_s[WIDTH-1:0];
            cout_s = add_s[WIDTH];
            ovf_s  = add_ovf(a_in[WIDTH-1], b_in[WIDTH-1], add_s[WIDTH-1]);
         end
      endcase
   end

`ifdef ALU_PIPE_MUL_EN
   alu_mul_seq #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (push_s & is_mul_s),
      .a       (a_in),
      .b       (b_in),
      .done    (mul_done_s),
      .product (mul_prod_s)
   );

   // Control FSM: park in ST_MUL while the multiplier runs, holding its tag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         mul_tag_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (push_s && is_mul_s) begin
                  state_r   <= ST_MUL;
                  mul_tag_r <= tag_in;
               end
            end
            ST_MUL: begin
               if (mul_done_s) begin
                  state_r <= ST_IDLE;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end
`endif

   // Output register: load on a single-cycle push or multiplier completion,
   // otherwise drop valid on a pop and hold everything else stable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         alu_out_r   <= '0;
         tag_out_r   <= '0;
         zero_r      <= 1'b0;
         overflow_r  <= 1'b0;
         carry_r     <= 1'b0;
      end else if (push_s && !is_mul_s) begin
         out_valid_r <= 1'b1;
         alu_out_r   <= res_s;
         tag_out_r   <= tag_in;
         zero_r      <= (res_s == '0);
         overflow_r  <= ovf_s;
         carry_r     <= cout_s;
`ifdef ALU_PIPE_MUL_EN
      end else if (mul_done_s) begin
         out_valid_r <= 1'b1;
         alu_out_r   <= mul_prod_s[WIDTH-1:0];
         tag_out_r   <= mul_tag_r;
         zero_r      <= (mul_prod_s[WIDTH-1:0] == '0);
         overflow_r  <= 1'b0;
         carry_r     <= |mul_prod_s[2*WIDTH-1:WIDTH];
`endif
      end else if (pop_s) begin
         // covers an accepted MUL that pops the previous result the same cycle
         out_valid_r <= 1'b0;
      end
   end

   assign out_valid = out_valid_r;
   assign alu_out   = alu_out_r;
   assign tag_out   = tag_out_r;
   assign zero      = zero_r;
   assign overflow  = overflow_r;
   assign carry_out = carry_r;

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a_in = 32'h0;
   logic [31:0] b_in = 32'h0;
   logic [3:0]  alu_ctrl = 4'h0;
   logic [3:0]  tag_in = 4'h0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] alu_out;
   logic [3:0]  tag_out;
   logic        zero;
   logic        overflow;
   logic        carry_out;

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  tag;
      logic [31:0] res;
      logic        z;
      logic        o;
      logic        c;
   } vec_t;

   vec_t vecs[$];

   alu_pipe #(.WIDTH(32), .TAG_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .b_in      (b_in),
      .alu_ctrl  (alu_ctrl),
      .tag_in    (tag_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alu_out   (alu_out),
      .tag_out   (tag_out),
      .zero      (zero),
      .overflow  (overflow),
      .carry_out (carry_out)
   );

   always #5 clk = ~clk;

   // packed view: {out_valid, tag, zero, ovf, carry, result}
   function automatic logic [39:0] obs();
      return {out_valid, tag_out, zero, overflow, carry_out, alu_out};
   endfunction

   task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag, input logic [31:0] res,
                          input logic z, input logic o, input logic c);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.tag = tag; v.res = res; v.z = z; v.o = o; v.c = c;
      vecs.push_back(v);
   endtask

   // present one op at a negedge and hold it until accepted at a posedge
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag);
      bit ok;
      @(negedge clk);
      alu_ctrl = op; a_in = a; b_in = b; tag_in = tag; in_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL issue_timeout: got in_ready=0 expected 1 within 50 cycles");
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      check("reset_state", {in_ready, obs()}, 40'h0);
      @(negedge clk);
      rst = 1'b0;

      add_vec(4'b0010, 32'hFFFFFFFF, 32'h00000001, 4'h1, 32'h00000000, 1'b1, 1'b0, 1'b1);
      add_vec(4'b0010, 32'h7FFFFFFF, 32'h00000001, 4'h2, 32'h80000000, 1'b0, 1'b1, 1'b0);
      add_vec(4'b0110, 32'h80000000, 32'h00000001, 4'h3, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1);
      add_vec(4'b0110, 32'h00000005, 32'h00000005, 4'h4, 32'h00000000, 1'b1, 1'b0, 1'b1);
      add_vec(4'b0110, 32'h00000003, 32'h00000005, 4'h5, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
      add_vec(4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 4'h6, 32'hF000F000, 1'b0, 1'b0, 1'b0);
      add_vec(4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 4'h7, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0);
      add_vec(4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 4'h8, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0);
      add_vec(4'b1100, 32'h00000000, 32'h00000000, 4'h9, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
      add_vec(4'b0111, 32'hFFFFFFFF, 32'h00000001, 4'hA, 32'h00000001, 1'b0, 1'b0, 1'b0);
      add_vec(4'b1001, 32'hFFFFFFFF, 32'h00000001, 4'hB, 32'h00000000, 1'b1, 1'b0, 1'b0);
      add_vec(4'b1000, 32'h80000000, 32'h00000021, 4'hC, 32'hC0000000, 1'b0, 1'b0, 1'b0);
      add_vec(4'b0100, 32'h00000001, 32'h0000001F, 4'hD, 32'h80000000, 1'b0, 1'b0, 1'b0);
      add_vec(4'b0100, 32'h00000001, 32'h00000020, 4'hE, 32'h00000001, 1'b0, 1'b0, 1'b0);
      add_vec(4'b0101, 32'h80000000, 32'h00000004, 4'hF, 32'h08000000, 1'b0, 1'b0, 1'b0);
      add_vec(4'b1111, 32'h00001234, 32'h00001234, 4'h1, 32'h00000001, 1'b0, 1'b0, 1'b0);
      add_vec(4'b1111, 32'h00000001, 32'h00000002, 4'h2, 32'h00000000, 1'b1, 1'b0, 1'b0);
      add_vec(4'b1101, 32'h00000002, 32'h00000003, 4'h3, 32'h00000005, 1'b0, 1'b0, 1'b0);
      add_vec(4'b1011, 32'h80000000, 32'h80000000, 4'h4, 32'h00000000, 1'b1, 1'b1, 1'b1);
`ifndef ALU_PIPE_MUL_EN
      add_vec(4'b1010, 32'h00000007, 32'h00000008, 4'h5, 32'h0000000F, 1'b0, 1'b0, 1'b0);
`endif

      // table-driven single-cycle ops, out_ready held high
      out_ready = 1'b1;
      foreach (vecs[i]) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
         @(negedge clk);
         check($sformatf("vec%0d_op%b", i, vecs[i].op), obs(),
               {1'b1, vecs[i].tag, vecs[i].z, vecs[i].o, vecs[i].c, vecs[i].res});
      end
      @(negedge clk);
      check("drain_valid_low", {39'h0, out_valid}, 40'h0);

      // backpressure: first result holds, second waits, then pop+push together
      out_ready = 1'b0;
      issue(4'b0010, 32'h1, 32'h2, 4'h1);
      @(negedge clk);
      check("bp_first_result", {in_ready, obs()}, {1'b0, 1'b1, 4'h1, 3'b000, 32'h3});
      alu_ctrl = 4'b0011; a_in = 32'h5; b_in = 32'h3; tag_in = 4'h2; in_valid = 1'b1;
      repeat (2) @(negedge clk);
      check("bp_hold_stable", {in_ready, obs()}, {1'b0, 1'b1, 4'h1, 3'b000, 32'h3});
      out_ready = 1'b1;
      #1;
      check("bp_ready_on_pop", {39'h0, in_ready}, 40'h1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("bp_second_result", obs(), {1'b1, 4'h2, 3'b000, 32'h6});
      @(negedge clk);
      check("bp_drained", {39'h0, out_valid}, 40'h0);

      // reset while a result is held
      out_ready = 1'b0;
      issue(4'b0010, 32'h1, 32'h1, 4'h3);
      @(negedge clk);
      check("rst_held_pre", obs(), {1'b1, 4'h3, 3'b000, 32'h2});
      rst = 1'b1;
      #1;
      check("rst_held_clear", {in_ready, obs()}, 40'h0);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;

`ifdef ALU_PIPE_MUL_EN
      begin
         int  cyc;
         bit  ready_seen;
         bit  got;
         logic [31:0] ma [3];
         logic [31:0] mb [3];
         logic [31:0] mr [3];
         logic        mz [3];
         logic        mc [3];
         ma[0] = 32'h00010000; mb[0] = 32'h00010000; mr[0] = 32'h0;        mz[0] = 1'b1; mc[0] = 1'b1;
         ma[1] = 32'h00000007; mb[1] = 32'h00000009; mr[1] = 32'h3F;       mz[1] = 1'b0; mc[1] = 1'b0;
         ma[2] = 32'hFFFFFFFF; mb[2] = 32'h00000002; mr[2] = 32'hFFFFFFFE; mz[2] = 1'b0; mc[2] = 1'b1;
         for (int m = 0; m < 3; m++) begin
            issue(4'b1010, ma[m], mb[m], 4'(m + 6));
            cyc = 0;
            ready_seen = 1'b0;
            got = 1'b0;
            for (int k = 0; k < 40; k++) begin
               @(posedge clk);
               #1;
               cyc++;
               if (out_valid) begin
                  got = 1'b1;
                  break;
               end
               if (in_ready) ready_seen = 1'b1;
            end
            check($sformatf("mul%0d_latency", m), 40'(cyc), 40'd32);
            check($sformatf("mul%0d_ready_low", m), {39'h0, ready_seen}, 40'h0);
            check($sformatf("mul%0d_result", m), obs(),
                  {got, 4'(m + 6), mz[m], 1'b0, mc[m], mr[m]});
            @(negedge clk);
         end

         // reset mid-multiply: abandon, no stale result afterwards
         issue(4'b1010, 32'h3, 32'h5, 4'h9);
         repeat (5) @(negedge clk);
         rst = 1'b1;
         #1;
         check("rst_mid_mul_clear", {in_ready, obs()}, 40'h0);
         @(negedge clk);
         rst = 1'b0;
         got = 1'b0;
         for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
         end
         check("rst_mid_mul_no_stale", {39'h0, got}, 40'h0);
         check("rst_mid_mul_ready", {39'h0, in_ready}, 40'h1);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
